tile_writeback: RTL
===================

Name: tile_writeback

Overview:
- Result-side responder to the tile sequencer.
- Takes finished output rows from the 4x4 MAC array and queues them in a 4-entry FIFO.
- Writes each row into the 16-word output memory. When ACC is set, it does read-modify-write accumulation (the second N-tile pass); otherwise it overwrites.
- Pulses Tile_Done once the row flagged last has been committed. Also performs the output-memory clear sweep at job start.

Parameters:
- DW, 16: width of one accumulator lane; a memory word holds 4 lanes.
- FDEPTH, 4: row FIFO depth (power of 2).
- OWORDS, 16: output memory words; address width 4.

Ports:
- CLK  in  1  clock; all logic is on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- CLR  in  1  pulse; starts the zero-fill of all OWORDS words.
- PE_VALID  in  1  a row result is presented this cycle.
- PE_DATA  in  4*DW  row result; lane k is at bits [k*DW +: DW].
- PE_LAST  in  1  qualifies PE_VALID; marks the final row of the tile.
- ODST  in  4  destination word address {m,t,row}; sampled with PE_VALID.
- ACC  in  1  accumulate into existing contents; sampled with PE_VALID.
- OMEM_EN  out  1  memory access strobe.
- OMEM_WE  out  1  1 = write, 0 = read.
- OMEM_ADDR  out  4  memory word address.
- OMEM_WDATA  out  4*DW  write data.
- OMEM_RDATA  in  4*DW  read data; valid exactly 1 cycle after a read strobe.
- Tile_Done  out  1  1-cycle pulse after the last row's write.
- BUSY  out  1  state != IDLE, or FIFO not empty.
- OVF  out  1  sticky; a row was dropped because the FIFO was full.

Behaviour:
- Reset values (all outputs and state):
  - OMEM_EN=0, OMEM_WE=0, OMEM_ADDR=0, OMEM_WDATA=0.
  - Tile_Done=0, BUSY=0, OVF=0.
  - FIFO empty, state IDLE, clear counter 0.
- Reset mid-operation: any in-flight read-modify-write is abandoned and no partial write is issued.
- FIFO:
  - Entry = {ODST, ACC, PE_LAST, PE_DATA}.
  - Push on PE_VALID. Push and pop in the same cycle are legal, including when the FIFO is full.
  - Push while full with no pop in that cycle: entry is dropped and OVF is set.
  - OVF clears only on RST or CLR.
- FSM states: IDLE, CLEAR, WR, RD, RMW, DONE.
- IDLE:
  - CLR → CLEAR. CLR wins over a non-empty FIFO.
  - Otherwise, if the FIFO is non-empty: go to RD if head ACC=1, else WR.
- CLEAR:
  - Writes zero to addresses 0..OWORDS-1, one per cycle (EN=1, WE=1, WDATA=0), then → IDLE.
  - PE_VALID pushes during CLEAR are still accepted.
  - CLR while not in IDLE is ignored.
- WR:
  - Writes the head row: EN=1, WE=1, ADDR=head ODST, WDATA=head data. Head is popped.
  - If head LAST → DONE.
  - Otherwise, if the FIFO still holds an entry after the pop → RD/WR according to that entry's ACC.
  - Otherwise → IDLE.
- RD: EN=1, WE=0, ADDR=head ODST → RMW.
- RMW:
  - EN=1, WE=1, same ADDR.
  - WDATA lane k = (OMEM_RDATA lane k + head lane k) mod 2^DW. Unsigned wrap; no saturation; no carry between lanes.
  - Head is popped. Next-state rules are the same as WR.
- DONE:
  - Tile_Done=1 for exactly this one cycle; no memory access.
  - Then → RD/WR if the FIFO is non-empty (next tile's rows), else → IDLE.
- Latency:
  - Non-acc row pushed at cycle 0 into an idle, empty block: write at cycle 2.
  - Acc row: read at 2, write at 3.
  - Tile_Done follows one cycle after the last row's write.
- Throughput: 1 row/cycle for non-acc, 1 row/2 cycles for acc.
- All outputs are registered or decoded from the state register, with no combinational path from PE_* to OMEM_*.

Test Plan:
- Overwrite tile:
  - Stimulus: CLR, then 4 rows, ODST 0..3, ACC=0, data lanes = row index; PE_LAST on row 3.
  - Required: 16 zero writes, then writes to addresses 0,1,2,3 on consecutive cycles; Tile_Done a single pulse 1 cycle after the address-3 write; BUSY low afterwards.
- Accumulate pass:
  - Stimulus: preload word 5 with lanes {1,2,3,4}; push ACC=1, ODST=5, data {10,20,30,40}, LAST.
  - Required: read of 5, then write of {11,22,33,44} on the next cycle; Tile_Done the cycle after that.
- Wrap:
  - Stimulus: memory lane = 16'hFFFF, pushed lane = 16'h0002, ACC=1.
  - Required: written lane = 16'h0001, with neighbouring lanes unaffected.
- Overflow:
  - Stimulus: 6 back-to-back ACC=1 rows right after CLR, so the FIFO fills during CLEAR.
  - Required: only the first 4 rows are committed; OVF=1 and stays high until the next CLR.
- Back-to-back tiles:
  - Stimulus: two 2-row tiles pushed contiguously.
  - Required: two separate Tile_Done pulses, each after its own LAST row; no write is lost or reordered.
- Reset mid-RMW:
  - Stimulus: RST asserted in the RMW cycle.
  - Required: no write is issued in the following cycle; all outputs are at their reset values; the FIFO is empty.

Source files
------------

// File: rtl/tile_writeback.sv
// Result-side writeback for the 4x4 MAC array: queues finished rows in a small FIFO and
// commits them to output memory, overwriting or accumulating, plus the job-start clear sweep.
module tile_writeback #(
    parameter int DW     = 16,
    parameter int FDEPTH = 4,
    parameter int OWORDS = 16
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            CLR,
    input  logic            PE_VALID,
    input  logic [4*DW-1:0] PE_DATA,
    input  logic            PE_LAST,
    input  logic [3:0]      ODST,
    input  logic            ACC,
    output logic            OMEM_EN,
    output logic            OMEM_WE,
    output logic [3:0]      OMEM_ADDR,
    output logic [4*DW-1:0] OMEM_WDATA,
    input  logic [4*DW-1:0] OMEM_RDATA,
    output logic            Tile_Done,
    output logic            BUSY,
    output logic            OVF
);

    localparam int PW = $clog2(FDEPTH);

    typedef struct packed {
        logic [3:0]      dst;
        logic            acc;
        logic            last;
        logic [4*DW-1:0] data;
    } entry_t;

    typedef enum logic [2:0] {IDLE, CLEAR, WR, RD, RMW, DONE} state_t;

    state_t        state, state_n;
    logic [3:0]    clr_cnt, clr_cnt_n;

    entry_t        fifo_mem [FDEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr_inc;
    logic [PW:0]   count;
    entry_t        head, in_entry, next_head;
    logic          full, push, pop, more_after_pop;

    assign in_entry   = '{dst: ODST, acc: ACC, last: PE_LAST, data: PE_DATA};
    assign head       = fifo_mem[rd_ptr];
    assign rd_ptr_inc = rd_ptr + 1'b1;
    assign full       = (count == (PW+1)'(FDEPTH));
    assign pop        = (state == WR) || (state == RMW);
    assign push       = PE_VALID && (!full || pop);

    // The row following the popped head is either already queued or arriving this cycle.
    assign more_after_pop = (count > (PW+1)'(1)) || push;
    assign next_head      = (count > (PW+1)'(1)) ? fifo_mem[rd_ptr_inc] : in_entry;

    assign BUSY = (state != IDLE) || (count != '0);

    // NOTE: row storage has no reset; the pointers and count alone define what is valid,
    // so leaving the array unreset keeps it a plain RAM without a reset fan-out.
    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr] <= in_entry;
    end

    // NOTE: every sequential block uses non-blocking assignments so all registers
    // update together at the edge, independent of block ordering.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            OVF    <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr_inc;
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
            if (CLR) OVF <= 1'b0;
            if (PE_VALID && full && !pop) OVF <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_n;
            clr_cnt <= clr_cnt_n;
        end
    end

    // NOTE: every output and next-state value is defaulted first so no path infers a latch.
    always_comb begin
        state_n    = state;
        clr_cnt_n  = clr_cnt;
        OMEM_EN    = 1'b0;
        OMEM_WE    = 1'b0;
        OMEM_ADDR  = '0;
        OMEM_WDATA = '0;
        Tile_Done  = 1'b0;
        case (state)
            IDLE: begin
                if (CLR)                state_n = CLEAR;
                else if (count != '0)   state_n = head.acc ? RD : WR;
            end
            CLEAR: begin
                OMEM_EN   = 1'b1;
                OMEM_WE   = 1'b1;
                OMEM_ADDR = clr_cnt;
                clr_cnt_n = clr_cnt + 1'b1;
                if (clr_cnt == 4'(OWORDS - 1)) begin
                    clr_cnt_n = '0;
                    state_n   = IDLE;
                end
            end
            WR, RMW: begin
                OMEM_EN   = 1'b1;
                OMEM_WE   = 1'b1;
                OMEM_ADDR = head.dst;
                if (state == WR) begin
                    OMEM_WDATA = head.data;
                end else begin
                    // Lane-wise modular add; carries never cross lane boundaries.
                    for (int k = 0; k < 4; k++)
                        OMEM_WDATA[k*DW +: DW] = OMEM_RDATA[k*DW +: DW] + head.data[k*DW +: DW];
                end
                if (head.last)          state_n = DONE;
                else if (more_after_pop) state_n = next_head.acc ? RD : WR;
                else                    state_n = IDLE;
            end
            RD: begin
                OMEM_EN   = 1'b1;
                OMEM_ADDR = head.dst;
                state_n   = RMW;
            end
            DONE: begin
                Tile_Done = 1'b1;
                if (count != '0) state_n = head.acc ? RD : WR;
                else             state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule
